ysyx_24110006_trap_ctrl: RTL and testbench

Trap sequencer for the machine-mode CSR file. It accepts ecall, mret and illegal-instruction requests from the writeback stage, plus an optional timer interrupt. It then walks a multi-cycle state machine that drives the CSR file's single write port and a dedicated read port to save and restore mepc, mcause and mstatus. It finishes with a one-cycle PC redirect to the fetch unit. The core stalls on `o_ready` while a trap is in flight.

---
 rtl/ysyx_24110006_csr_pkg.sv | 55 +++++
 rtl/ysyx_24110006_trap_ctrl.sv | 136 +++++++++++++
 tb/tb_ysyx_24110006_trap_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24110006_csr_pkg.sv
// Shared CSR definitions for the machine-mode trap sequencer: addresses, causes, mstatus fields, FSM states.
// No logic of its own; the mstatus helpers below are purely combinational.
// Used with or without YSYX_24110006_TIMER_IRQ_EN.
package ysyx_24110006_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int CAUSE_ECALL    = 11;
    localparam int CAUSE_ILLEGAL  = 2;
    localparam int CAUSE_IRQ_CODE = 7;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [1:0] {
        KIND_ECALL   = 2'd0,
        KIND_MRET    = 2'd1,
        KIND_ILLEGAL = 2'd2,
        KIND_RSVD    = 2'd3
    } req_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE_EPC,
        ST_SAVE_CAUSE,
        ST_UPD_STATUS,
        ST_RST_STATUS,
        ST_REDIRECT
    } trap_state_e;

    // Only the low 13 bits of mstatus carry the fields touched here; callers splice the rest back.
    function automatic logic [12:0] mstatus_trap(input logic [12:0] s);
        logic [12:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [12:0] mstatus_ret(input logic [12:0] s);
        logic [12:0] r;
        r = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/ysyx_24110006_trap_ctrl.sv
// Trap sequencer: saves mepc/mcause/mstatus through the CSR write port, then pulses a PC redirect.
// Latency: trap accept->redirect 4 cycles, mret 2 cycles; optional timer irq under YSYX_24110006_TIMER_IRQ_EN.
// Backpressure: o_ready is high only in IDLE; requests seen while busy are ignored and must be held upstream.
module ysyx_24110006_trap_ctrl
    import ysyx_24110006_csr_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MTVEC_ALIGN = 2
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_valid,
    input  logic [1:0]      i_kind,
    input  logic [XLEN-1:0] i_pc,
`ifdef YSYX_24110006_TIMER_IRQ_EN
    input  logic            i_irq,
    input  logic [XLEN-1:0] i_irq_pc,
`endif
    output logic            o_ready,
    output logic            o_csr_wen,
    output logic [11:0]     o_csr_addr,
    output logic [XLEN-1:0] o_csr_wdata,
    output logic [11:0]     o_csr_raddr,
    input  logic [XLEN-1:0] i_csr_rdata,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_upc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << MTVEC_ALIGN) - XLEN'(1));

    trap_state_e     state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    req_kind_e       kind_q, kind_d;
    req_kind_e       req_kind;
    logic            wen_raw;
    logic            redirect_raw;

    assign req_kind = req_kind_e'(i_kind);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cause_q <= '0;
            kind_q  <= KIND_ECALL;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
            kind_q  <= kind_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        cause_d      = cause_q;
        kind_d       = kind_q;
        o_ready      = 1'b0;
        wen_raw      = 1'b0;
        redirect_raw = 1'b0;
        o_csr_addr   = '0;
        o_csr_wdata  = '0;
        o_csr_raddr  = CSR_MSTATUS;
        o_upc        = '0;

        case (state_q)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    pc_d   = i_pc;
                    kind_d = req_kind;
                    if (req_kind == KIND_MRET) begin
                        state_d = ST_RST_STATUS;
                    end else begin
                        state_d = ST_SAVE_EPC;
                        cause_d = (req_kind == KIND_ECALL) ? XLEN'(CAUSE_ECALL)
                                                           : XLEN'(CAUSE_ILLEGAL);
                    end
                end
`ifdef YSYX_24110006_TIMER_IRQ_EN
                // mstatus is on the read port in IDLE, so MIE gating needs no extra port.
                else if (i_irq && i_csr_rdata[MSTATUS_MIE]) begin
                    o_ready = 1'b0;
                    pc_d    = i_irq_pc;
                    cause_d = {1'b1, (XLEN-1)'(CAUSE_IRQ_CODE)};
                    kind_d  = KIND_ECALL;
                    state_d = ST_SAVE_EPC;
                end
`endif
            end
            ST_SAVE_EPC: begin
                wen_raw     = 1'b1;
                o_csr_addr  = CSR_MEPC;
                o_csr_wdata = pc_q;
                state_d     = ST_SAVE_CAUSE;
            end
            ST_SAVE_CAUSE: begin
                wen_raw     = 1'b1;
                o_csr_addr  = CSR_MCAUSE;
                o_csr_wdata = cause_q;
                state_d     = ST_UPD_STATUS;
            end
            ST_UPD_STATUS: begin
                wen_raw     = 1'b1;
                o_csr_addr  = CSR_MSTATUS;
                o_csr_wdata = {i_csr_rdata[XLEN-1:13], mstatus_trap(i_csr_rdata[12:0])};
                state_d     = ST_REDIRECT;
            end
            ST_RST_STATUS: begin
                wen_raw     = 1'b1;
                o_csr_addr  = CSR_MSTATUS;
                o_csr_wdata = {i_csr_rdata[XLEN-1:13], mstatus_ret(i_csr_rdata[12:0])};
                state_d     = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_raw = 1'b1;
                state_d      = ST_IDLE;
                if (kind_q == KIND_MRET) begin
                    o_csr_raddr = CSR_MEPC;
                    o_upc       = i_csr_rdata;
                end else begin
                    o_csr_raddr = CSR_MTVEC;
                    o_upc       = i_csr_rdata & ALIGN_MASK;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset landing on a write/redirect cycle must suppress that side effect too.
    assign o_csr_wen  = wen_raw & ~i_reset;
    assign o_redirect = redirect_raw & ~i_reset;

endmodule

// File: tb/tb_ysyx_24110006_trap_ctrl.sv
// Randomized self-checking bench for the trap sequencer, with a small CSR file model driving i_csr_rdata.
// Define YSYX_24110006_TIMER_IRQ_EN to include the interrupt scenarios.
module tb_ysyx_24110006_trap_ctrl;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic [1:0]  i_kind;
    logic [31:0] i_pc;
`ifdef YSYX_24110006_TIMER_IRQ_EN
    logic        i_irq;
    logic [31:0] i_irq_pc;
`endif
    logic        o_ready;
    logic        o_csr_wen;
    logic [11:0] o_csr_addr;
    logic [31:0] o_csr_wdata;
    logic [11:0] o_csr_raddr;
    logic [31:0] i_csr_rdata;
    logic        o_redirect;
    logic [31:0] o_upc;

    logic [31:0] ms, vec, epc, mc;
    int checks = 0;
    int errors = 0;

    always #5 i_clock = ~i_clock;

    ysyx_24110006_trap_ctrl #(.XLEN(32), .MTVEC_ALIGN(2)) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .i_kind      (i_kind),
        .i_pc        (i_pc),
`ifdef YSYX_24110006_TIMER_IRQ_EN
        .i_irq       (i_irq),
        .i_irq_pc    (i_irq_pc),
`endif
        .o_ready     (o_ready),
        .o_csr_wen   (o_csr_wen),
        .o_csr_addr  (o_csr_addr),
        .o_csr_wdata (o_csr_wdata),
        .o_csr_raddr (o_csr_raddr),
        .i_csr_rdata (i_csr_rdata),
        .o_redirect  (o_redirect),
        .o_upc       (o_upc)
    );

    always_comb begin
        case (o_csr_raddr)
            12'h300: i_csr_rdata = ms;
            12'h305: i_csr_rdata = vec;
            12'h341: i_csr_rdata = epc;
            12'h342: i_csr_rdata = mc;
            default: i_csr_rdata = 32'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: commit any DUT write into the CSR model at the edge, then sample after the falling edge.
    task automatic tick();
        logic        w;
        logic [11:0] a;
        logic [31:0] d;
        w = o_csr_wen; a = o_csr_addr; d = o_csr_wdata;
        @(posedge i_clock);
        if (w) begin
            case (a)
                12'h300: ms  = d;
                12'h305: vec = d;
                12'h341: epc = d;
                12'h342: mc  = d;
                default: ;
            endcase
        end
        @(negedge i_clock);
        #1;
    endtask

    task automatic step_write(input string tag, input logic [11:0] a, input logic [31:0] d);
        chk({tag, "_wen"},   32'(o_csr_wen), 32'd1);
        chk({tag, "_addr"},  32'(o_csr_addr), 32'(a));
        chk({tag, "_wdata"}, o_csr_wdata, d);
        chk({tag, "_busy"},  32'(o_ready), 32'd0);
        chk({tag, "_noredir"}, 32'(o_redirect), 32'd0);
        tick();
    endtask

    // Expected behaviour derived from the architectural rules, on full 32-bit values.
    task automatic check_seq(input bit is_ret, input logic [31:0] pc, input logic [31:0] cause,
                             input logic [31:0] ms0, input logic [31:0] vec0, input logic [31:0] epc0);
        logic [31:0] new_ms, tgt;
        if (is_ret) begin
            new_ms = (ms0 & ~32'h0000_1888) | ((ms0 >> 4) & 32'h8) | 32'h0000_1880;
            tgt    = epc0;
        end else begin
            new_ms = (ms0 & ~32'h0000_1888) | ((ms0 & 32'h8) << 4) | 32'h0000_1800;
            tgt    = vec0 & ~32'h3;
            step_write("mepc", 12'h341, pc);
            step_write("mcause", 12'h342, cause);
        end
        step_write("mstatus", 12'h300, new_ms);
        chk("redirect",       32'(o_redirect), 32'd1);
        chk("redirect_upc",   o_upc, tgt);
        chk("redirect_raddr", 32'(o_csr_raddr), is_ret ? 32'h341 : 32'h305);
        chk("redirect_nowen", 32'(o_csr_wen), 32'd0);
        tick();
        chk("ready_back", 32'(o_ready), 32'd1);
        chk("redirect_off", 32'(o_redirect), 32'd0);
    endtask

    task automatic run_req(input logic [1:0] kind, input logic [31:0] pc,
                           input logic nv, input logic [1:0] nkind, input logic [31:0] npc);
        logic [31:0] ms0, vec0, epc0, cause;
        int n;
        i_valid = 1'b1; i_kind = kind; i_pc = pc;
        #1;
        n = 0;
        while (!o_ready && n < 20) begin
            tick();
            n++;
        end
        chk("accept_ready", 32'(o_ready), 32'd1);
        ms0 = ms; vec0 = vec; epc0 = epc;
        cause = (kind == 2'd0) ? 32'd11 : 32'd2;
        tick();
        i_valid = nv; i_kind = nkind; i_pc = npc;
        #1;
        check_seq(kind == 2'd1, pc, cause, ms0, vec0, epc0);
    endtask

    initial begin
        logic [31:0] keep_mc;
        logic [31:0] rpc;
        logic [1:0]  rk;
        i_reset = 1'b1; i_valid = 1'b0; i_kind = 2'd0; i_pc = 32'h0;
`ifdef YSYX_24110006_TIMER_IRQ_EN
        i_irq = 1'b0; i_irq_pc = 32'h0;
`endif
        ms = 32'h0; vec = 32'h0; epc = 32'h0; mc = 32'h0;
        @(negedge i_clock); #1;
        tick();
        tick();
        i_reset = 1'b0;
        #1;
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_wen",   32'(o_csr_wen), 32'd0);
        chk("rst_redir", 32'(o_redirect), 32'd0);
        chk("rst_upc",   o_upc, 32'd0);
        chk("rst_addr",  32'(o_csr_addr), 32'd0);
        chk("rst_wdata", o_csr_wdata, 32'd0);
        chk("rst_raddr", 32'(o_csr_raddr), 32'h300);
        tick();

        // Directed ecall and mret from the reference scenarios
        ms = 32'h8; vec = 32'h8000_0403;
        run_req(2'd0, 32'h8000_0100, 1'b0, 2'd0, 32'h0);
        chk("ecall_mstatus_final", ms, 32'h0000_1880);
        epc = 32'h8000_0104; ms = 32'h1880;
        run_req(2'd1, 32'h1234_5678, 1'b0, 2'd0, 32'h0);
        chk("mret_mstatus_final", ms, 32'h0000_1888);

        // Illegal held while an ecall is in flight, then accepted
        run_req(2'd0, 32'h8000_0200, 1'b1, 2'd2, 32'h8000_0300);
        run_req(2'd2, 32'h8000_0300, 1'b0, 2'd0, 32'h0);
        chk("held_illegal_mcause", mc, 32'd2);

        // Random requests, including the reserved kind
        for (int i = 0; i < 24; i++) begin
            ms  = $urandom;
            vec = $urandom;
            epc = $urandom;
            rk  = 2'($urandom_range(0, 3));
            rpc = $urandom;
            run_req(rk, rpc, 1'b0, 2'd0, 32'h0);
            if ($urandom_range(0, 1) == 1) tick();
        end

`ifdef YSYX_24110006_TIMER_IRQ_EN
        ms = 32'h8; vec = 32'h8000_0800;
        i_irq = 1'b1; i_irq_pc = 32'h8000_0200;
        #1;
        chk("irq_ready_drop", 32'(o_ready), 32'd0);
        tick();
        i_irq = 1'b0;
        #1;
        check_seq(1'b0, 32'h8000_0200, 32'h8000_0007, 32'h8, 32'h8000_0800, epc);
        ms = 32'h0; i_irq = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("irq_masked_ready", 32'(o_ready), 32'd1);
            chk("irq_masked_wen", 32'(o_csr_wen), 32'd0);
            tick();
        end
        ms = 32'h8;
        run_req(2'd0, 32'h8000_0500, 1'b0, 2'd0, 32'h0);
        chk("irq_vs_ecall_cause", mc, 32'd11);
        i_irq = 1'b0;
        tick();
`endif

        // Reset landing in SAVE_CAUSE
        ms = 32'h8; vec = 32'h8000_0403; mc = 32'hdead_beef; keep_mc = mc;
        i_valid = 1'b1; i_kind = 2'd0; i_pc = 32'h8000_0900;
        #1;
        tick();
        i_valid = 1'b0;
        #1;
        chk("rstseq_epc_wen", 32'(o_csr_wen), 32'd1);
        tick();
        i_reset = 1'b1;
        #1;
        chk("rstseq_wen_suppressed", 32'(o_csr_wen), 32'd0);
        tick();
        i_reset = 1'b0;
        #1;
        chk("rstseq_ready", 32'(o_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("rstseq_no_wen", 32'(o_csr_wen), 32'd0);
            chk("rstseq_no_redirect", 32'(o_redirect), 32'd0);
            tick();
        end
        chk("rstseq_mcause_kept", mc, keep_mc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
